// File: rtl/piano_pkg.sv
// Shared note definitions for the keyboard piano: note codes, pitch table,
// half-period arithmetic and the tone generator state encoding.
package piano_pkg;
  localparam int NOTE_W    = 4;
  localparam int CNT_W     = 18;
  localparam int NUM_NOTES = 13;

  localparam logic [NOTE_W-1:0] NOTE_SILENT = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_C4     = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_CS4    = 4'd2;
  localparam logic [NOTE_W-1:0] NOTE_D4     = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_DS4    = 4'd4;
  localparam logic [NOTE_W-1:0] NOTE_E4     = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_F4     = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_FS4    = 4'd7;
  localparam logic [NOTE_W-1:0] NOTE_G4     = 4'd8;
  localparam logic [NOTE_W-1:0] NOTE_GS4    = 4'd9;
  localparam logic [NOTE_W-1:0] NOTE_A4     = 4'd10;
  localparam logic [NOTE_W-1:0] NOTE_AS4    = 4'd11;
  localparam logic [NOTE_W-1:0] NOTE_B4     = 4'd12;
  localparam logic [NOTE_W-1:0] NOTE_C5     = 4'd13;

  // Pitch in centi-Hertz, C4 up to C5.
  localparam int unsigned FREQ_CHZ [NUM_NOTES] = '{
    26163, 27718, 29366, 31113, 32963, 34923, 36999,
    39200, 41530, 44000, 46616, 49388, 52325};

  typedef enum logic {IDLE, PLAY} state_e;

  function automatic bit is_note(input logic [NOTE_W-1:0] code);
    return (code >= NOTE_C4) && (code <= NOTE_C5);
  endfunction

  function automatic longint unsigned half_period_wide(input logic [NOTE_W-1:0] code,
                                                       input longint unsigned clk_hz);
    longint unsigned f;
    f = 64'd0;
    for (int i = 0; i < NUM_NOTES; i++)
      if (int'(code) == i + 1) f = 64'(FREQ_CHZ[i]);
    if (f == 64'd0) return 64'd0;
    return (clk_hz * 64'd100) / (64'd2 * f);
  endfunction

  function automatic logic [CNT_W-1:0] half_period(input logic [NOTE_W-1:0] code,
                                                   input longint unsigned clk_hz);
    return CNT_W'(half_period_wide(code, clk_hz));
  endfunction
endpackage

// File: rtl/note_period_lut.sv
// Note code to half-period lookup; every entry folds to a constant at elaboration.
module note_period_lut import piano_pkg::*; #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int          CNT_W  = 18,
  parameter int          NOTE_W = 4
) (
  input  logic [NOTE_W-1:0] note_code,
  output logic [CNT_W-1:0]  half_per
);
  logic [CNT_W-1:0] tbl [2**NOTE_W];

  for (genvar i = 0; i < 2**NOTE_W; i++) begin : g_tbl
    localparam longint unsigned HP = half_period_wide(NOTE_W'(i), 64'(CLK_HZ));
    assign tbl[i] = CNT_W'(HP);
  end

  assign half_per = tbl[note_code];
endmodule

// File: rtl/note_tone_gen.sv
// Square-wave tone generator: half-period counter with note changes deferred
// to the falling edge of the output so the waveform never glitches.
module note_tone_gen import piano_pkg::*; #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int          CNT_W  = 18,
  parameter int          NOTE_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              note_valid,
  input  logic [NOTE_W-1:0] note_code,
  output logic              note_ready,
  output logic              audio_out,
  output logic              playing,
  output logic [NOTE_W-1:0] cur_note
);
  // C4 is the lowest pitch, so it has the longest half-period.
  localparam longint unsigned MAX_HALF = half_period_wide(NOTE_C4, 64'(CLK_HZ));
  if (MAX_HALF >= (64'd1 << CNT_W)) begin : g_cnt_w_check
    $fatal(1, "CNT_W too narrow for the longest half-period at CLK_HZ");
  end

  state_e            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n, half_per, half_per_n, lut_half;
  logic [NOTE_W-1:0] cur_note_n, pend_code, pend_code_n, lut_code;
  logic              audio_n, pend_valid, pend_valid_n, accept, boundary;

  assign note_ready = !pend_valid;
  assign playing    = (state == PLAY);
  assign accept     = note_valid && note_ready;
  assign boundary   = (cnt == half_per - CNT_W'(1));
  // IDLE starts straight from the request; PLAY only ever loads from pend.
  assign lut_code   = (state == IDLE) ? note_code : pend_code;

  note_period_lut #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W), .NOTE_W(NOTE_W)) u_lut (
    .note_code (lut_code),
    .half_per  (lut_half)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      half_per   <= '0;
      audio_out  <= 1'b0;
      cur_note   <= '0;
      pend_valid <= 1'b0;
      pend_code  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      half_per   <= half_per_n;
      audio_out  <= audio_n;
      cur_note   <= cur_note_n;
      pend_valid <= pend_valid_n;
      pend_code  <= pend_code_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    half_per_n   = half_per;
    audio_n      = audio_out;
    cur_note_n   = cur_note;
    pend_valid_n = pend_valid;
    pend_code_n  = pend_code;
    case (state)
      IDLE: begin
        if (accept && is_note(note_code)) begin
          state_n    = PLAY;
          cur_note_n = note_code;
          half_per_n = lut_half;
          cnt_n      = '0;
          audio_n    = 1'b1;
        end
      end
      PLAY: begin
        // An accept can never coincide with the pend clear below: it needs pend_valid low.
        if (accept) begin
          pend_valid_n = 1'b1;
          pend_code_n  = note_code;
        end
        if (boundary) begin
          cnt_n   = '0;
          audio_n = !audio_out;
          if (audio_out && pend_valid) begin
            pend_valid_n = 1'b0;
            pend_code_n  = '0;
            if (is_note(pend_code)) begin
              half_per_n = lut_half;
              cur_note_n = pend_code;
            end else begin
              state_n    = IDLE;
              audio_n    = 1'b0;
              cur_note_n = '0;
            end
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: doc/note_tone_gen.md
Name: note_tone_gen

Overview:
- Square-wave tone generator for the PS/2 keyboard piano.
- Consumes note codes from the key-decode stage.
- Counts clock cycles against a per-note half-period and drives a 1-bit audio output to the speaker pin.
- Note changes are applied only at a falling-edge period boundary, so the output never glitches.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- CNT_W, 18, half-period counter width. Elaboration must fail if the largest half-period is not below 2^CNT_W.
- NOTE_W, 4, note code width.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset. When reset==0, all state clears immediately.
- note_valid  input  1  note_code is offered this cycle.
- note_code  input  NOTE_W  note request:
  - 0 = silence.
  - 1..13 = C4, C#4, D4, D#4, E4, F4, F#4, G4, G#4, A4, A#4, B4, C5.
  - 14..15 = invalid, treated as silence.
- note_ready  output  1  block can accept a request. A transfer occurs when note_valid && note_ready.
- audio_out  output  1  square-wave tone.
- playing  output  1  high while in PLAY.
- cur_note  output  NOTE_W  code currently sounding (0 when idle).

Behaviour:
- Reset values:
  - state=IDLE, cnt=0, half_per=0, audio_out=0, cur_note=0.
  - pend_valid=0, pend_code=0.
  - playing=0, note_ready=1.
- Half-period: half_per(code) = floor(CLK_HZ*100 / (2*freq_centiHz(code))).
  - freq_centiHz table, C4..C5: 26163, 27718, 29366, 31113, 32963, 34923, 36999, 39200, 41530, 44000, 46616, 49388, 52325.
  - Defaults: C4=95554, A4=56818, C5=47778.
- note_ready = !pend_valid. This is a registered-state decode with no combinational path from note_valid.
- IDLE:
  - Accepting code 1..13 loads cur_note=code, half_per=LUT(code), cnt=0, audio_out=1, state=PLAY. All are visible on the cycle after the accept (latency 1).
  - Accepting code 0/14/15 is a no-op. The handshake still completes.
- PLAY, counting:
  - cnt increments each cycle.
  - When cnt==half_per-1: cnt<=0 and audio_out toggles. This is the boundary.
  - Each phase therefore lasts exactly half_per cycles.
- PLAY, requests:
  - An accept stores pend_code and sets pend_valid, which drops note_ready.
  - The pending request is applied only at a falling boundary (audio_out 1->0).
    - Valid code: half_per and cur_note load; the low phase that starts uses the new half_per.
    - Silence or invalid code: state=IDLE, audio_out=0, cur_note=0, cnt=0.
  - pend_valid clears at that boundary either way.
  - Rising boundaries ignore pend.
- Same-note request: applied as above. half_per is unchanged, so there is no audible change.
- Accept in the same cycle as a falling boundary: captured into pend and applied at the next falling boundary, not the current one.
- Reset mid-operation returns to IDLE immediately, with audio_out=0 and any pending request discarded.
- cnt never exceeds half_per-1, and no wrap-around of cnt is possible.

Decomposition:
- Shared package piano_pkg:
  - NOTE_W.
  - Note-code constants NOTE_SILENT, NOTE_C4..NOTE_C5.
  - freq_centiHz constant array.
  - function half_period(code, clk_hz) returning CNT_W bits, with 0 for invalid codes.
  - state enum {IDLE, PLAY}.
- Sub-module note_period_lut: purely combinational; note_code in, half_per out; built from the package function.
- Control FSM, counter and pend register live in note_tone_gen.

Test Plan:
- Reset: hold reset=0 with random note_valid/note_code -> audio_out=0, playing=0, note_ready=1, cur_note=0.
- Start A4: in IDLE, one-cycle note_valid with code 10 -> next cycle audio_out=1, playing=1, cur_note=10. audio_out toggles every 56818 cycles (period 113636), with no pulse-width deviation over 4 periods.
- Change note: playing A4, send code 13 at 20000 cycles into the high phase -> note_ready=0 until the next falling edge. Then cur_note=13 and the following phases are each 47778 cycles. A second request offered while note_ready=0 is not accepted.
- Stop: playing C4 (code 1, half 95554), send code 0 mid-low-phase -> the tone continues through the next high phase, then at the falling edge audio_out=0, playing=0, cur_note=0, and it stays low.
- Reset mid-PLAY with a pending request: assert reset=0 asynchronously -> audio_out=0 and playing=0 without waiting for clk. After release, the block stays IDLE with note_ready=1 and the pending note discarded.
- Invalid/boundary: in IDLE send code 14 -> accepted, nothing plays. Then send code 1 coincident with nothing pending -> half-period 95554. During PLAY, issue an accept exactly on a falling-boundary cycle -> applied one full period later.
